chip8_mem_arbiter: RTL and testbench
====================================

Name: chip8_mem_arbiter

Overview:
- Sequences and shares the single-port 8-bit CHIP-8 program/data memory between three requesters: 0 = opcode fetch, 1 = CPU data (FX55/FX65/FX33/BCD), 2 = video sprite reader (DXYN).
- Each request is a burst of 1..16 consecutive bytes.
- The arbiter owns the memory address, write-enable and write-data lines.
- It returns read bytes, or consumes write bytes, one per cycle.

Parameters:
- ADDR_W, 12, memory address width; burst addresses wrap modulo 2^ADDR_W.
- NREQ, 3, number of requesters; fixed at 3, not intended to be overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  3  per-requester burst request; bit i = requester i.
- req_addr  in  3*ADDR_W  packed start addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_len  in  12  packed burst length minus 1; requester i at [i*4 +: 4].
- req_we  in  1  write burst flag; honoured for requester 1 only, ignored for 0 and 2.
- wdata  in  8  write byte from requester 1 for the current write beat.
- gnt  out  3  one-hot, one-cycle pulse when a burst is accepted.
- beat  out  3  one-hot; read: rdata valid this cycle; write: wdata consumed this cycle.
- rdata  out  8  read byte, shared by all requesters, qualified by beat.
- done  out  3  one-hot pulse coincident with the final beat of a burst.
- busy  out  1  high from grant until the cycle after done.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  8  memory write byte.
- mem_rdata  in  8  memory read byte, valid one cycle after mem_addr (synchronous read).

Behaviour:
- Reset: every output is 0, FSM is IDLE, round-robin pointer = 0. Reset is asynchronous: mem_we drops immediately and any in-flight burst is abandoned with no done.
- FSM states: IDLE, RBURST, WBURST, RTAIL.
- IDLE: if any req bit is set, pick a winner and latch its addr, len and the write flag (req_we && winner==1) into internal registers. Next state is RBURST or WBURST; gnt[winner] and busy are driven registered in that next cycle.
- Requester inputs (req, req_addr, req_len, req_we) must be held stable until gnt is seen; they are don't-care after gnt. Dropping req mid-burst does not stop the burst.
- RBURST: each cycle drive mem_addr = start+k (k = 0..L, wrapping), mem_we = 0.
  - One cycle later: beat[winner] = 1 and rdata = mem_rdata.
  - After address L is issued, go to RTAIL.
  - RTAIL delivers the last byte with beat and done, then returns to IDLE.
- Read latency: grant at cycle T, first address at T, first data at T+1, done at T+L+1.
- WBURST: on each cycle k drive mem_addr = start+k, mem_we = 1, mem_wdata = wdata, beat[1] = 1.
  - Requester 1 presents the next byte in the following cycle.
  - done[1] pulses on beat L; then IDLE.
- A length field of 0 gives one beat; 15 gives 16 beats.
- Address wrap example: start 0xFFF, len 1 accesses 0xFFF then 0x000.
- busy deasserts in the IDLE cycle that follows done. Arbitration occurs in that IDLE cycle, so at least 1 dead cycle separates consecutive bursts.
- Simultaneous requests: exactly one grant per arbitration; losers keep req held and are served later.
- A request arriving while busy is not considered until IDLE.
- mem_wdata and mem_addr are don't-care but held when no transfer is active; mem_we is 0 outside WBURST.

Optional Feature:
- Macro: CHIP8_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at (last winner + 1) mod 3, and the pointer updates on each grant.
- Undefined: fixed priority, requester 0 highest, then 1, then 2. The pointer register is not implemented.

Test Plan:
- Single read: req=001, addr0=0x200, len0=1, memory holds 0x12,0x34 -> gnt=001 at T, beat[0] with rdata 0x12 at T+1 and 0x34 at T+2, done[0] at T+2, busy low at T+3.
- Write burst: req=010, req_we=1, addr1=0x300, len1=3, wdata 0xA0..0xA3 -> mem_we at 4 consecutive cycles to 0x300..0x303; done[1] on the 4th; readback matches.
- Contention: req=111 held, each dropped after its done.
  - Fixed priority: grant order 0,1,2.
  - CHIP8_ARB_RR_EN: also 0,1,2 from reset. Re-raising req0 and req2 together after grant 0 gives 2 before 0.
- Wrap: requester 2, addr 0xFFE, len 3 -> mem_addr sequence 0xFFE, 0xFFF, 0x000, 0x001, with 4 beats and done[2].
- Reset mid-burst: assert rst_n=0 during beat 2 of a 16-beat write -> mem_we=0 immediately, no done. After release: busy=0, and a new req=001 is granted normally.
- req_we=1 on requester 0 -> treated as a read; mem_we stays 0.

Source files
------------

// File: rtl/chip8_mem_arbiter.sv
// chip8_mem_arbiter: shares the CHIP-8 single-port memory between fetch, CPU data and sprite bursts.
// Define CHIP8_ARB_RR_EN for round-robin arbitration; fixed priority (0 > 1 > 2) otherwise.
module chip8_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int NREQ = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*4-1:0]        req_len,
    input  logic                     req_we,
    input  logic [7:0]               wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          beat,
    output logic [7:0]               rdata,
    output logic [NREQ-1:0]          done,
    output logic                     busy,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [7:0]               mem_wdata,
    input  logic [7:0]               mem_rdata
);
    typedef enum logic [1:0] {IDLE, RBURST, WBURST, RTAIL} state_t;
    state_t state;
    logic [1:0] win;
    logic [2:0] win_oh, sel;
    logic [3:0] len_q, cnt, win_len;
    logic [ADDR_W-1:0] win_addr;
    logic [7:0] wdata_q;
    logic win_we;
`ifdef CHIP8_ARB_RR_EN
    logic [1:0] ptr;
    logic [2:0] slot;
    // Scan offsets from last to first so the closest requester after ptr wins.
    always_comb begin
        win = 2'd0;
        slot = 3'd0;
        for (int i = 2; i >= 0; i--) begin
            slot = {1'b0, ptr} + 3'(i);
            slot = slot >= 3'd3 ? slot - 3'd3 : slot;
            if (req[slot[1:0]]) win = slot[1:0];
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr <= 2'd0;
        else if (state == IDLE && |req) ptr <= win == 2'd2 ? 2'd0 : win + 2'd1;
`else
    assign win = req[0] ? 2'd0 : req[1] ? 2'd1 : 2'd2;
`endif
    assign win_oh = 3'b001 << win;
    assign win_addr = win == 2'd0 ? req_addr[0 +: ADDR_W] :
                      win == 2'd1 ? req_addr[ADDR_W +: ADDR_W] : req_addr[2*ADDR_W +: ADDR_W];
    assign win_len = win == 2'd0 ? req_len[3:0] : win == 2'd1 ? req_len[7:4] : req_len[11:8];
    assign win_we = req_we && win == 2'd1;
    // Write data passes straight through during a write beat and holds the last byte otherwise.
    assign mem_wdata = mem_we ? wdata : wdata_q;
    assign rdata = (|beat && !mem_we) ? mem_rdata : 8'h00;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 3'b000;
            len_q    <= 4'd0;
            cnt      <= 4'd0;
            gnt      <= 3'b000;
            beat     <= 3'b000;
            done     <= 3'b000;
            busy     <= 1'b0;
            mem_addr <= '0;
            mem_we   <= 1'b0;
            wdata_q  <= 8'h00;
        end else begin
            gnt <= 3'b000;
            if (mem_we) wdata_q <= wdata;
            case (state)
                IDLE: if (|req) begin
                    state    <= win_we ? WBURST : RBURST;
                    sel      <= win_oh;
                    len_q    <= win_len;
                    cnt      <= 4'd0;
                    gnt      <= win_oh;
                    busy     <= 1'b1;
                    mem_addr <= win_addr;
                    mem_we   <= win_we;
                    beat     <= win_we ? win_oh : 3'b000;
                    done     <= (win_we && win_len == 4'd0) ? win_oh : 3'b000;
                end
                RBURST: begin
                    beat <= sel;
                    done <= cnt == len_q ? sel : 3'b000;
                    if (cnt == len_q) state <= RTAIL;
                    else begin
                        cnt      <= cnt + 4'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                WBURST: if (cnt == len_q) begin
                    state  <= IDLE;
                    mem_we <= 1'b0;
                    beat   <= 3'b000;
                    done   <= 3'b000;
                    busy   <= 1'b0;
                end else begin
                    cnt      <= cnt + 4'd1;
                    mem_addr <= mem_addr + ADDR_W'(1);
                    done     <= cnt + 4'd1 == len_q ? sel : 3'b000;
                end
                RTAIL: begin
                    state <= IDLE;
                    beat  <= 3'b000;
                    done  <= 3'b000;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// tb_chip8_mem_arbiter: scoreboard bench for chip8_mem_arbiter with a synchronous-read memory model.
// Expectations for CHIP8_ARB_RR_EN follow the same macro.
module tb_chip8_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] req = 3'b000;
    logic [35:0] req_addr = '0;
    logic [11:0] req_len = '0;
    logic req_we = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [2:0] gnt, beat, done;
    logic [7:0] rdata, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic busy, mem_we;
    logic [11:0] mem_addr;
    logic [7:0] mem [4096];
    typedef struct {
        logic [2:0] beat;
        logic [11:0] addr;
        logic [7:0] data;
        logic done;
        logic we;
        int off;
    } exp_t;
    logic [2:0] gq[$];
    exp_t bq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    chip8_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
        .req_we(req_we), .wdata(wdata), .gnt(gnt), .beat(beat), .rdata(rdata), .done(done),
        .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask
    task automatic exp_rd(input int id, input logic [11:0] a, input logic [7:0] d, input logic dn, input int off);
        bq.push_back('{beat: 3'(1 << id), addr: a, data: d, done: dn, we: 1'b0, off: off});
    endtask
    task automatic exp_wr(input logic [11:0] a, input logic [7:0] d, input logic dn, input int off);
        bq.push_back('{beat: 3'b010, addr: a, data: d, done: dn, we: 1'b1, off: off});
    endtask
    task automatic serve(input logic [2:0] r, input logic we, input logic [7:0] wd);
        int n = 0;
        logic [2:0] d;
        logic b;
        req = r;
        req_we = we;
        wdata = wd;
        while (req != 3'b000 && n < 64) begin
            @(negedge clk);
            d = done;
            b = beat[1] & mem_we;
            @(posedge clk);
            #1;
            req = req & ~d;
            if (b) wdata = wdata + 8'd1;
            n++;
        end
        chk("serve_timeout", int'(req), 0);
        req_we = 1'b0;
    endtask
    // Monitor: pops expectations whenever the DUT shows a grant or a beat.
    initial begin
        int gcyc = 0;
        logic prev_done = 1'b0;
        logic [11:0] prev_addr = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_done) chk("busy_after_done", int'(busy), 0);
                if (mem_we) chk("we_without_beat", int'(beat), 3'b010);
                if (|gnt) begin
                    gcyc = cyc;
                    chk("gnt_busy", int'(busy), 1);
                    if (gq.size() == 0) chk("gnt_unexpected", int'(gnt), 0);
                    else chk("gnt", int'(gnt), int'(gq.pop_front()));
                end
                if (|beat) begin
                    if (bq.size() == 0) chk("beat_unexpected", int'(beat), 0);
                    else begin
                        e = bq.pop_front();
                        chk("beat_id", int'(beat), int'(e.beat));
                        chk("beat_offset", cyc - gcyc, e.off);
                        chk("done", int'(done), e.done ? int'(e.beat) : 0);
                        chk("mem_we", int'(mem_we), int'(e.we));
                        if (e.we) begin
                            chk("wr_addr", int'(mem_addr), int'(e.addr));
                            chk("wr_data", int'(mem_wdata), int'(e.data));
                        end else begin
                            chk("rd_addr", int'(prev_addr), int'(e.addr));
                            chk("rdata", int'(rdata), int'(e.data));
                        end
                    end
                end else if (|done) chk("done_without_beat", int'(done), 0);
                prev_done = |done;
            end else prev_done = 1'b0;
            prev_addr = mem_addr;
        end
    end
    initial begin
        int n;
        int nb;
        logic b;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h200] = 8'h12; mem[12'h201] = 8'h34; mem[12'h210] = 8'h56;
        mem[12'h220] = 8'h78; mem[12'h221] = 8'h9A;
        mem[12'hFFE] = 8'hC1; mem[12'hFFF] = 8'hC2; mem[12'h000] = 8'hC3; mem[12'h001] = 8'hC4;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_beat", int'(beat), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_rdata", int'(rdata), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // single read
        req_addr = {12'h000, 12'h000, 12'h200};
        req_len = {4'd0, 4'd0, 4'd1};
        gq.push_back(3'b001);
        exp_rd(0, 12'h200, 8'h12, 1'b0, 1);
        exp_rd(0, 12'h201, 8'h34, 1'b1, 2);
        serve(3'b001, 1'b0, 8'h00);
        // write burst then readback through requester 0
        req_addr = {12'h000, 12'h300, 12'h300};
        req_len = {4'd0, 4'd3, 4'd3};
        gq.push_back(3'b010);
        exp_wr(12'h300, 8'hA0, 1'b0, 0);
        exp_wr(12'h301, 8'hA1, 1'b0, 1);
        exp_wr(12'h302, 8'hA2, 1'b0, 2);
        exp_wr(12'h303, 8'hA3, 1'b1, 3);
        serve(3'b010, 1'b1, 8'hA0);
        gq.push_back(3'b001);
        exp_rd(0, 12'h300, 8'hA0, 1'b0, 1);
        exp_rd(0, 12'h301, 8'hA1, 1'b0, 2);
        exp_rd(0, 12'h302, 8'hA2, 1'b0, 3);
        exp_rd(0, 12'h303, 8'hA3, 1'b1, 4);
        serve(3'b001, 1'b0, 8'h00);
        // contention with all three requesting
        req_addr = {12'h220, 12'h210, 12'h200};
        req_len = {4'd1, 4'd0, 4'd0};
        gq.push_back(3'b001);
        exp_rd(0, 12'h200, 8'h12, 1'b1, 1);
        gq.push_back(3'b010);
        exp_rd(1, 12'h210, 8'h56, 1'b1, 1);
        gq.push_back(3'b100);
        exp_rd(2, 12'h220, 8'h78, 1'b0, 1);
        exp_rd(2, 12'h221, 8'h9A, 1'b1, 2);
        serve(3'b111, 1'b0, 8'h00);
        // grant 0, then 0 and 2 together
        gq.push_back(3'b001);
        exp_rd(0, 12'h200, 8'h12, 1'b1, 1);
        serve(3'b001, 1'b0, 8'h00);
`ifdef CHIP8_ARB_RR_EN
        gq.push_back(3'b100);
        exp_rd(2, 12'h220, 8'h78, 1'b0, 1);
        exp_rd(2, 12'h221, 8'h9A, 1'b1, 2);
        gq.push_back(3'b001);
        exp_rd(0, 12'h200, 8'h12, 1'b1, 1);
`else
        gq.push_back(3'b001);
        exp_rd(0, 12'h200, 8'h12, 1'b1, 1);
        gq.push_back(3'b100);
        exp_rd(2, 12'h220, 8'h78, 1'b0, 1);
        exp_rd(2, 12'h221, 8'h9A, 1'b1, 2);
`endif
        serve(3'b101, 1'b0, 8'h00);
        // address wrap on requester 2
        req_addr = {12'hFFE, 12'h000, 12'h000};
        req_len = {4'd3, 4'd0, 4'd0};
        gq.push_back(3'b100);
        exp_rd(2, 12'hFFE, 8'hC1, 1'b0, 1);
        exp_rd(2, 12'hFFF, 8'hC2, 1'b0, 2);
        exp_rd(2, 12'h000, 8'hC3, 1'b0, 3);
        exp_rd(2, 12'h001, 8'hC4, 1'b1, 4);
        serve(3'b100, 1'b0, 8'h00);
        // req_we on requester 0 is a read
        req_addr = {12'h000, 12'h000, 12'h201};
        req_len = {4'd0, 4'd0, 4'd0};
        gq.push_back(3'b001);
        exp_rd(0, 12'h201, 8'h34, 1'b1, 1);
        serve(3'b001, 1'b1, 8'h00);
        // reset during the third beat of a 16-beat write
        req_addr = {12'h000, 12'h400, 12'h000};
        req_len = {4'd0, 4'd15, 4'd0};
        gq.push_back(3'b010);
        exp_wr(12'h400, 8'hB0, 1'b0, 0);
        exp_wr(12'h401, 8'hB1, 1'b0, 1);
        exp_wr(12'h402, 8'hB2, 1'b0, 2);
        req = 3'b010;
        req_we = 1'b1;
        wdata = 8'hB0;
        n = 0;
        nb = 0;
        while (nb < 3 && n < 64) begin
            @(negedge clk);
            n++;
            b = beat[1];
            if (b) nb++;
            if (nb < 3) begin
                @(posedge clk);
                #1;
                if (b) wdata = wdata + 8'd1;
            end
        end
        chk("rst_burst_reached", nb, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mem_we", int'(mem_we), 0);
        chk("async_done", int'(done), 0);
        chk("async_beat", int'(beat), 0);
        chk("async_busy", int'(busy), 0);
        req = 3'b000;
        req_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_done", int'(done), 0);
        req_addr = {12'h000, 12'h000, 12'h200};
        req_len = {4'd0, 4'd0, 4'd0};
        gq.push_back(3'b001);
        exp_rd(0, 12'h200, 8'h12, 1'b1, 1);
        serve(3'b001, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("gnt_queue_empty", gq.size(), 0);
        chk("beat_queue_empty", bq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
